// File: rtl/loot_spawner_if.sv
// Signal bundle between the loot spawner and the rest of the playfield:
// game-state and player inputs, per-player offers and renderer lookups.
interface loot_spawner_if;
  logic       SpawnEnable;
  logic [9:0] P1X;
  logic [9:0] P1Y;
  logic [9:0] P2X;
  logic [9:0] P2Y;
  logic [4:0] P1HbOffset;
  logic [4:0] P2HbOffset;
  logic       P1Collected;
  logic       P2Collected;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [1:0] P1Collect;
  logic [1:0] P2Collect;
  logic       ItemPixel;
  logic [1:0] ItemValue;
  logic [3:0] ItemPixelX;
  logic [3:0] ItemPixelY;

  modport master (
    output SpawnEnable, P1X, P1Y, P2X, P2Y, P1HbOffset, P2HbOffset,
           P1Collected, P2Collected, DrawX, DrawY,
    input  P1Collect, P2Collect, ItemPixel, ItemValue, ItemPixelX, ItemPixelY
  );

  modport slave (
    input  SpawnEnable, P1X, P1Y, P2X, P2Y, P1HbOffset, P2HbOffset,
           P1Collected, P2Collected, DrawX, DrawY,
    output P1Collect, P2Collect, ItemPixel, ItemValue, ItemPixelX, ItemPixelY
  );
endinterface

// File: rtl/loot_spawner.sv
// Loot item slots: LFSR-driven (re)spawn, per-player offer/collect handshake
// and combinational item lookup for the renderer.
module loot_spawner #(
  parameter int          NUM_SLOTS      = 4,
  parameter int          RESPAWN_FRAMES = 120,
  parameter int          INIT_STAGGER   = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input logic           FrameClk,
  input logic           ResetN,
  loot_spawner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OFFER, WAIT} fsm_t;

  logic [15:0]          lfsr;
  logic [NUM_SLOTS-1:0] active, locked;
  logic [1:0]           value [NUM_SLOTS];
  logic [9:0]           pos_x [NUM_SLOTS];
  logic [9:0]           pos_y [NUM_SLOTS];
  logic [9:0]           timer [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit1, hit2, spawn;
  logic [NUM_SLOTS-1:0] lock_set, lock_clr, clear;
  logic [NUM_SLOTS-1:0] pmask1, pmask2, claim1;
  logic                 found1, found2;
  logic [2:0]           pick1, pick2;
  logic [1:0]           val1, val2;
  fsm_t                 st1, st1_nx, st2, st2_nx;
  logic [2:0]           idx1, idx1_nx, idx2, idx2_nx;
  logic [1:0]           col1, col1_nx, col2, col2_nx;

  // Strict overlap of the player's foot hitbox with a 16x16 item box.
  function automatic logic overlap(input logic [9:0] px, input logic [9:0] py,
                                   input logic [4:0] hb, input logic [9:0] ix,
                                   input logic [9:0] iy);
    logic [11:0] ax, ay, bx, by;
    ax = {2'b00, px} + {7'd0, hb};
    ay = {2'b00, py} + 12'd16;
    bx = {2'b00, ix};
    by = {2'b00, iy};
    return (ax < bx + 12'd16) && (bx < ax + 12'd16) &&
           (ay < by + 12'd16) && (by < ay + 12'd16);
  endfunction

  function automatic logic in_span(input logic [9:0] d, input logic [9:0] p);
    return ({1'b0, d} >= {1'b0, p}) && ({1'b0, d} < {1'b0, p} + 11'd16);
  endfunction

  // Free-running Fibonacci LFSR, taps 16/14/13/11, shifted right.
  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // Per-slot spawn condition and hitbox overlap for both players.
  always_comb begin
    spawn = '0;
    hit1  = '0;
    hit2  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      spawn[i] = !active[i] && (timer[i] == 10'd0) && bus.SpawnEnable;
      hit1[i]  = overlap(bus.P1X, bus.P1Y, bus.P1HbOffset, pos_x[i], pos_y[i]);
      hit2[i]  = overlap(bus.P2X, bus.P2Y, bus.P2HbOffset, pos_x[i], pos_y[i]);
    end
  end

  // Both player FSMs; P1 claims first so P2 never sees the slot P1 takes now.
  always_comb begin
    found1 = 1'b0; pick1 = '0; val1 = '0; pmask1 = '0;
    found2 = 1'b0; pick2 = '0; val2 = '0; pmask2 = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!found1 && active[i] && !locked[i] && hit1[i]) begin
        found1    = 1'b1;
        pick1     = 3'(i);
        val1      = value[i];
        pmask1[i] = 1'b1;
      end
    end
    claim1 = (st1 == IDLE && found1) ? pmask1 : '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!found2 && active[i] && !locked[i] && !claim1[i] && hit2[i]) begin
        found2    = 1'b1;
        pick2     = 3'(i);
        val2      = value[i];
        pmask2[i] = 1'b1;
      end
    end

    st1_nx = st1; idx1_nx = idx1; col1_nx = col1;
    st2_nx = st2; idx2_nx = idx2; col2_nx = col2;
    lock_set = '0; lock_clr = '0; clear = '0;

    case (st1)
      IDLE: if (found1) begin
        st1_nx = OFFER; idx1_nx = pick1; col1_nx = val1; lock_set = lock_set | pmask1;
      end
      OFFER: begin st1_nx = WAIT; col1_nx = 2'd0; end
      WAIT: begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (idx1 == 3'(i)) begin
            lock_clr[i] = 1'b1;
            clear[i]    = bus.P1Collected;
          end
        end
        st1_nx = IDLE;
      end
      default: begin st1_nx = IDLE; col1_nx = 2'd0; end
    endcase

    case (st2)
      IDLE: if (found2) begin
        st2_nx = OFFER; idx2_nx = pick2; col2_nx = val2; lock_set = lock_set | pmask2;
      end
      OFFER: begin st2_nx = WAIT; col2_nx = 2'd0; end
      WAIT: begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (idx2 == 3'(i)) begin
            lock_clr[i] = 1'b1;
            clear[i]    = clear[i] | bus.P2Collected;
          end
        end
        st2_nx = IDLE;
      end
      default: begin st2_nx = IDLE; col2_nx = 2'd0; end
    endcase

    if (!bus.SpawnEnable) begin
      st1_nx = IDLE; col1_nx = 2'd0;
      st2_nx = IDLE; col2_nx = 2'd0;
    end
  end

  // FSM state, locked slot index and registered offer outputs.
  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) begin
      st1 <= IDLE; idx1 <= '0; col1 <= '0;
      st2 <= IDLE; idx2 <= '0; col2 <= '0;
    end else begin
      st1 <= st1_nx; idx1 <= idx1_nx; col1 <= col1_nx;
      st2 <= st2_nx; idx2 <= idx2_nx; col2 <= col2_nx;
    end
  end

  // Slot control: disable/reset restore the staggered start, else clear/spawn/count.
  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) begin
      active <= '0;
      locked <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) timer[i] <= 10'(INIT_STAGGER * (i + 1));
    end else if (!bus.SpawnEnable) begin
      active <= '0;
      locked <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) timer[i] <= 10'(INIT_STAGGER * (i + 1));
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (clear[i]) begin
          active[i] <= 1'b0;
          timer[i]  <= 10'(RESPAWN_FRAMES);
        end else if (spawn[i]) begin
          active[i] <= 1'b1;
        end else if (!active[i] && timer[i] != 10'd0) begin
          timer[i] <= timer[i] - 10'd1;
        end
        locked[i] <= (locked[i] | lock_set[i]) & ~lock_clr[i];
      end
    end
  end

  // Item position/value captured from the LFSR on spawn; meaningless while inactive.
  always_ff @(posedge FrameClk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (spawn[i]) begin
        pos_x[i] <= 10'd116 + {1'b0, lfsr[8:0]};
        pos_y[i] <= 10'd120 + {2'b00, lfsr[15:8]};
        value[i] <= (lfsr[1:0] == 2'd0) ? 2'd1 : lfsr[1:0];
      end
    end
  end

  // Renderer lookup; iterating downward lets the lowest covering slot win.
  always_comb begin
    bus.ItemPixel  = 1'b0;
    bus.ItemValue  = 2'd0;
    bus.ItemPixelX = 4'd0;
    bus.ItemPixelY = 4'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (active[i] && in_span(bus.DrawX, pos_x[i]) && in_span(bus.DrawY, pos_y[i])) begin
        bus.ItemPixel  = 1'b1;
        bus.ItemValue  = value[i];
        bus.ItemPixelX = 4'(bus.DrawX - pos_x[i]);
        bus.ItemPixelY = 4'(bus.DrawY - pos_y[i]);
      end
    end
  end

  assign bus.P1Collect = col1;
  assign bus.P2Collect = col2;
endmodule

// File: tb/tb_loot_spawner.sv
// Directed bench for loot_spawner: reset, staggered first spawn, accepted and
// refused collects, two-player contention, disable mid-handshake, rendering.
module tb_loot_spawner;
  localparam int          NS   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  loot_spawner_if bus();

  loot_spawner #(
    .NUM_SLOTS(NS), .RESPAWN_FRAMES(120), .INIT_STAGGER(8), .LFSR_SEED(SEED)
  ) dut (
    .FrameClk(clk),
    .ResetN  (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int e     = 0;
  int m_act [NS];
  int m_x   [NS];
  int m_y   [NS];
  int m_v   [NS];
  int spawn_at [NS];

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, e);
    end
  endtask

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l;
    l = SEED;
    for (int k = 1; k < n; k++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    return l;
  endfunction

  function automatic int px_of(input logic [15:0] l);
    return 116 + int'(l[8:0]);
  endfunction

  function automatic int py_of(input logic [15:0] l);
    return 120 + int'(l[15:8]);
  endfunction

  task automatic tick();
    logic [15:0] l;
    @(posedge clk);
    #1;
    e++;
    l = lfsr_at(e);
    for (int i = 0; i < NS; i++) begin
      if (m_act[i] == 0 && spawn_at[i] == e) begin
        m_act[i] = 1;
        m_x[i]   = px_of(l);
        m_y[i]   = py_of(l);
        m_v[i]   = (l[1:0] == 2'd0) ? 1 : int'(l[1:0]);
      end
    end
  endtask

  task automatic check_render(input string tag, input int dx, input int dy);
    int ep = 0, ev = 0, ex = 0, ey = 0;
    bus.DrawX = 10'(dx);
    bus.DrawY = 10'(dy);
    #1;
    for (int i = NS - 1; i >= 0; i--) begin
      if (m_act[i] != 0 && dx >= m_x[i] && dx < m_x[i] + 16 &&
          dy >= m_y[i] && dy < m_y[i] + 16) begin
        ep = 1; ev = m_v[i]; ex = dx - m_x[i]; ey = dy - m_y[i];
      end
    end
    check_val({tag, "_pix"}, int'(bus.ItemPixel), ep);
    check_val({tag, "_val"}, int'(bus.ItemValue), ev);
    check_val({tag, "_ofsx"}, int'(bus.ItemPixelX), ex);
    check_val({tag, "_ofsy"}, int'(bus.ItemPixelY), ey);
  endtask

  task automatic away();
    bus.P1X = 10'd0; bus.P1Y = 10'd0;
    bus.P2X = 10'd0; bus.P2Y = 10'd0;
  endtask

  task automatic over_p1(input int s);
    bus.P1HbOffset = 5'd0;
    bus.P1X = 10'(m_x[s]);
    bus.P1Y = 10'(m_y[s] - 16);
  endtask

  task automatic over_p2(input int s);
    bus.P2HbOffset = 5'd16;
    bus.P2X = 10'(m_x[s] - 16);
    bus.P2Y = 10'(m_y[s] - 16);
  endtask

  // One edge with SpawnEnable low (caller lowers it); restarts the stagger.
  task automatic disable_edge();
    for (int i = 0; i < NS; i++) spawn_at[i] = -1;
    tick();
    for (int i = 0; i < NS; i++) begin
      m_act[i]    = 0;
      spawn_at[i] = e + 8 * (i + 1) + 1;
    end
  endtask

  task automatic restart();
    away();
    bus.P1Collected = 1'b0;
    bus.P2Collected = 1'b0;
    bus.SpawnEnable = 1'b0;
    disable_edge();
    bus.SpawnEnable = 1'b1;
  endtask

  task automatic collect_pair(input string tag, input int p1, input int p2);
    check_val({tag, "_p1"}, int'(bus.P1Collect), p1);
    check_val({tag, "_p2"}, int'(bus.P2Collect), p2);
  endtask

  initial begin
    int clr, ox, oy, v;
    logic [15:0] l;
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_v[i] = 0;
      spawn_at[i] = 8 * (i + 1) + 1;
    end
    bus.SpawnEnable = 1'b1;
    bus.P1HbOffset  = 5'd0;
    bus.P2HbOffset  = 5'd16;
    bus.P1Collected = 1'b0;
    bus.P2Collected = 1'b0;
    bus.DrawX = 10'd200;
    bus.DrawY = 10'd200;
    away();

    // Reset held with spawning enabled: nothing offered or drawn.
    repeat (2) @(posedge clk);
    #3;
    collect_pair("rst", 0, 0);
    check_val("rst_pix", int'(bus.ItemPixel), 0);
    check_val("rst_val", int'(bus.ItemValue), 0);
    rst_n = 1'b1;

    // First spawn: slot 0 at edge 9, slot 3 at edge 33.
    repeat (8) tick();
    l = lfsr_at(9);
    check_render("pre_spawn0", px_of(l) + 5, py_of(l) + 9);
    tick();
    check_val("spawn0_model", m_act[0], 1);
    check_render("spawn0", m_x[0] + 5, m_y[0] + 9);
    check_render("spawn0_edge", m_x[0] + 16, m_y[0]);
    while (e < 32) tick();
    l = lfsr_at(33);
    check_render("pre_spawn3", px_of(l) + 5, py_of(l) + 9);
    tick();
    check_render("spawn3", m_x[3] + 5, m_y[3] + 9);

    // Accepted collect, then respawn RESPAWN_FRAMES+1 edges after the clear.
    restart();
    repeat (9) tick();
    over_p1(0);
    v = m_v[0];
    tick();
    collect_pair("acc_pulse", v, 0);
    tick();
    collect_pair("acc_end", 0, 0);
    bus.P1Collected = 1'b1;
    ox = m_x[0]; oy = m_y[0];
    away();
    tick();
    clr = e;
    m_act[0] = 0;
    spawn_at[0] = clr + 121;
    bus.P1Collected = 1'b0;
    check_render("acc_cleared", ox + 5, oy + 9);
    l = lfsr_at(clr + 121);
    while (e < clr + 120) tick();
    check_render("respawn_pre", px_of(l) + 5, py_of(l) + 9);
    tick();
    check_val("respawn_model", m_act[0], 1);
    check_render("respawn", px_of(l) + 5, py_of(l) + 9);

    // Refused collect: slot stays, re-offered every third frame.
    restart();
    repeat (9) tick();
    over_p1(0);
    v = m_v[0];
    tick();
    collect_pair("ref_k0", v, 0);
    tick();
    collect_pair("ref_k1", 0, 0);
    tick();
    collect_pair("ref_k2", 0, 0);
    tick();
    collect_pair("ref_k3", v, 0);
    check_render("ref_active", m_x[0] + 5, m_y[0] + 9);
    tick();
    collect_pair("ref_k4", 0, 0);

    // Both players on slot 0, P1 accepts: P2 never offered.
    restart();
    repeat (9) tick();
    over_p1(0);
    over_p2(0);
    v = m_v[0];
    tick();
    collect_pair("sim_acc_k0", v, 0);
    tick();
    collect_pair("sim_acc_k1", 0, 0);
    bus.P1Collected = 1'b1;
    tick();
    m_act[0] = 0;
    spawn_at[0] = e + 121;
    bus.P1Collected = 1'b0;
    collect_pair("sim_acc_k2", 0, 0);
    tick();
    collect_pair("sim_acc_k3", 0, 0);

    // Both players on slot 0, P1 refuses and walks off: P2 offered next.
    restart();
    repeat (9) tick();
    over_p1(0);
    over_p2(0);
    v = m_v[0];
    tick();
    collect_pair("sim_ref_k0", v, 0);
    tick();
    collect_pair("sim_ref_k1", 0, 0);
    bus.P1X = 10'd0; bus.P1Y = 10'd0;
    tick();
    collect_pair("sim_ref_k2", 0, 0);
    tick();
    collect_pair("sim_ref_k3", 0, v);

    // Disable while P1 waits for Collected; the late Collected is ignored.
    restart();
    repeat (9) tick();
    over_p1(0);
    v = m_v[0];
    ox = m_x[0]; oy = m_y[0];
    tick();
    collect_pair("dis_k0", v, 0);
    tick();
    bus.SpawnEnable = 1'b0;
    bus.P1Collected = 1'b1;
    disable_edge();
    collect_pair("dis_k2", 0, 0);
    check_render("dis_cleared", ox + 5, oy + 9);
    bus.SpawnEnable = 1'b1;
    clr = e;
    tick();
    bus.P1Collected = 1'b0;
    while (e < clr + 8) tick();
    l = lfsr_at(clr + 9);
    check_render("dis_pre_respawn", px_of(l) + 5, py_of(l) + 9);
    tick();
    check_render("dis_respawn", m_x[0] + 5, m_y[0] + 9);
    over_p1(0);
    tick();
    collect_pair("dis_reoffer", m_v[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
